// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes and the master FSM
// state type. Imported by axi_master_burst and its testbench.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WDATA,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } state_t;

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the write-data and read-data phases of a burst.
// Restarts at beat 0 on load, counts handshakes, and flags the final beat.
module axi_beat_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_last
);

  logic [LEN_W-1:0] r_count;

  // Restart on load; saturate instead of wrapping when a slave overruns the burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {LEN_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_last = (r_count == i_len);

endmodule

// File: rtl/axi_master_burst.sv
// Command-driven AXI4 burst master. One command at a time: a write burst fed
// from a valid/ready client stream, or a read burst delivered as a valid-only
// stream. Completion is a one-cycle done pulse carrying the AXI response.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort a stalled burst
// with DECERR after TMO_CYCLES cycles without any channel handshake.
module axi_master_burst
  import axi_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int STRB_W = 4,
  parameter int RESP_W = 2
`ifdef AXI_MASTER_TIMEOUT_EN
  ,
  parameter int TMO_CYCLES = 64
`endif
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [1:0]        cmd_burst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              done,
  output logic [RESP_W-1:0] done_resp,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [RESP_W-1:0] bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [RESP_W-1:0] rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  function automatic logic [RESP_W-1:0] resp_max(input logic [RESP_W-1:0] a,
                                                 input logic [RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t              r_state;
  logic                r_cmd_ready, r_awvalid, r_arvalid, r_bready, r_rready;
  logic                r_rd_valid, r_rd_last, r_done, r_rlast_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [1:0]          r_burst;
  logic [DATA_W-1:0]   r_rd_data;
  logic [RESP_W-1:0]   r_done_resp, r_rresp_max;

  logic w_load, w_inc, w_last, w_in_wdata, w_wvalid;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_tmo, w_rlast_err_now;
  logic [RESP_W-1:0] w_rresp_now;

  assign w_load     = cmd_valid && r_cmd_ready;
  assign w_in_wdata = (r_state == ST_WDATA);
  assign w_wvalid   = w_in_wdata && wr_valid;
  assign w_aw_hs    = r_awvalid && awready;
  assign w_w_hs     = w_wvalid && wready;
  assign w_b_hs     = r_bready && bvalid;
  assign w_ar_hs    = r_arvalid && arready;
  assign w_r_hs     = r_rready && rvalid;
  assign w_inc      = w_w_hs || w_r_hs;

  // Running read status including the beat being accepted this cycle
  assign w_rresp_now     = resp_max(r_rresp_max, rresp);
  assign w_rlast_err_now = r_rlast_err || (rlast != w_last);

  axi_beat_counter #(.LEN_W(LEN_W)) u_beat_cnt (
    .clk    (aclk),
    .rst_n  (aresetn),
    .i_load (w_load),
    .i_inc  (w_inc),
    .i_len  (r_len),
    .o_last (w_last)
  );

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
  logic [TMO_W-1:0] r_wdog;
  logic             w_any_hs;

  assign w_any_hs = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
  assign w_tmo    = (r_wdog == TMO_W'(TMO_CYCLES));

  // Watchdog counts busy cycles and restarts on any channel handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wdog <= '0;
    end else if ((r_state == ST_IDLE) || w_any_hs || w_tmo) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Burst sequencer: command capture, channel valids/readies and completion
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_done_resp <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_burst     <= '0;
      r_rresp_max <= '0;
      r_rlast_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      if (w_tmo) begin
        r_awvalid   <= 1'b0;
        r_arvalid   <= 1'b0;
        r_bready    <= 1'b0;
        r_rready    <= 1'b0;
        r_done      <= 1'b1;
        r_done_resp <= RESP_W'(RESP_DECERR);
        r_cmd_ready <= 1'b1;
        r_state     <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cmd_ready <= 1'b1;
            if (w_load) begin
              r_cmd_ready <= 1'b0;
              r_addr      <= cmd_addr;
              r_len       <= cmd_len;
              r_burst     <= cmd_burst;
              r_rresp_max <= '0;
              r_rlast_err <= 1'b0;
              if (cmd_write) begin
                r_awvalid <= 1'b1;
                r_state   <= ST_WADDR;
              end else begin
                r_arvalid <= 1'b1;
                r_state   <= ST_RADDR;
              end
            end
          end
          ST_WADDR: begin
            if (w_aw_hs) begin
              r_awvalid <= 1'b0;
              r_state   <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (w_w_hs && w_last) begin
              r_bready <= 1'b1;
              r_state  <= ST_WRESP;
            end
          end
          ST_WRESP: begin
            if (w_b_hs) begin
              r_bready    <= 1'b0;
              r_done      <= 1'b1;
              r_done_resp <= bresp;
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
          ST_RADDR: begin
            if (w_ar_hs) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
              r_state   <= ST_RDATA;
            end
          end
          ST_RDATA: begin
            if (w_r_hs) begin
              r_rd_valid  <= 1'b1;
              r_rd_data   <= rdata;
              r_rd_last   <= w_last;
              r_rresp_max <= w_rresp_now;
              r_rlast_err <= w_rlast_err_now;
              if (rlast) begin
                r_rready    <= 1'b0;
                r_done      <= 1'b1;
                r_done_resp <= w_rlast_err_now ? RESP_W'(RESP_SLVERR) : w_rresp_now;
                r_cmd_ready <= 1'b1;
                r_state     <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign awaddr    = r_addr;
  assign awlen     = r_len;
  assign awburst   = r_burst;
  assign awvalid   = r_awvalid;
  assign araddr    = r_addr;
  assign arlen     = r_len;
  assign arburst   = r_burst;
  assign arvalid   = r_arvalid;
  assign wvalid    = w_wvalid;
  assign wdata     = w_in_wdata ? wr_data : '0;
  assign wstrb     = w_in_wdata ? {STRB_W{1'b1}} : '0;
  assign wlast     = w_in_wdata && w_last;
  assign wr_ready  = w_w_hs;
  assign bready    = r_bready;
  assign rready    = r_rready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign done      = r_done;
  assign done_resp = r_done_resp;

endmodule

// File: tb/tb_axi_master_burst.sv
// Testbench for axi_master_burst: directed table of bursts, randomized bursts
// scored against a transaction-level model, reset and watchdog sequences.
module tb_axi_master_burst;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [3:0]  cmd_addr = 0, cmd_len = 0;
  logic [1:0]  cmd_burst = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic        wr_valid = 0, wr_ready, rd_valid, rd_last, done;
  logic [1:0]  done_resp;
  logic [3:0]  awaddr, araddr, awlen, arlen;
  logic [1:0]  awburst, arburst, bresp = 0, rresp = 0;
  logic        awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready;
  logic        arvalid, arready = 0, rlast = 0, rvalid = 0, rready;
  logic [31:0] wdata, rdata = 0;
  logic [3:0]  wstrb;

  always #5 aclk = ~aclk;

  axi_master_burst #(.ADDR_W(4), .DATA_W(32), .LEN_W(4), .STRB_W(4), .RESP_W(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .done_resp(done_resp),
    .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // One burst: command fields, slave behaviour, client mode and expected status.
  // mode 0 = always ready, 1 = random handshakes, 2 = scripted gap/stall.
  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [1:0]  resp;      // bresp, or rresp of the final read beat
    int          rlast_at;  // read beat index carrying rlast
    int          mode;
    logic [31:0] base;      // write beat i carries base+i
    bit          hold_cmd;  // keep cmd_valid high for the whole burst
    logic [1:0]  exp_resp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit coin();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic vec_t mk(bit wr, logic [3:0] addr, logic [3:0] len, logic [1:0] burst,
                              logic [1:0] resp, int rlast_at, int mode, logic [31:0] base,
                              bit hold, logic [1:0] exp_resp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.burst = burst; v.resp = resp;
    v.rlast_at = rlast_at; v.mode = mode; v.base = base; v.hold_cmd = hold;
    v.exp_resp = exp_resp;
    return v;
  endfunction

  // Transaction-level expectation: write reports bresp; read reports SLVERR on
  // any rlast/length disagreement, else the worst rresp the slave sent.
  function automatic logic [1:0] model_resp(vec_t v, logic [1:0] rq[$]);
    logic [1:0] m = 2'b00;
    if (v.wr) return v.resp;
    if (v.rlast_at != int'(v.len)) return RESP_SLVERR;
    foreach (rq[i]) if (rq[i] > m) m = rq[i];
    return m;
  endfunction

  function automatic logic any_out();
    return |{cmd_ready, awvalid, awaddr, awlen, awburst, wvalid, wdata, wstrb, wlast,
             wr_ready, bready, arvalid, araddr, arlen, arburst, rready, rd_valid,
             rd_data, rd_last, done, done_resp};
  endfunction

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic issue(input vec_t v);
    int w = 0;
    @(negedge aclk);
    while (!cmd_ready && w < 20) begin
      @(negedge aclk);
      w++;
    end
    check("cmd_ready_idle", 64'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_burst = v.burst;
  endtask

  task automatic run_txn(input vec_t v, input bit use_tbl);
    logic [31:0] wgot[$], rsent[$], rgot[$];
    logic [1:0]  rq[$];
    bit          wlg[$], rlg[$];
    int aw_cnt = 0, ar_cnt = 0, done_cnt = 0, post = 0, widx = 0, werr = 0;
    int gap = 0, stall = 0, err = 0, cyc;
    bit aw_done = 0, ar_done = 0, b_done = 0, w_pend = 0, r_pend = 0, prev_stall = 0;
    logic [31:0] prev_wdata = 0;
    logic [1:0]  resp_got = 0, exp;
    logic [9:0]  aw_f = 0, ar_f = 0;
    int nbeats = int'(v.len) + 1;
    int nsend  = v.wr ? 0 : v.rlast_at + 1;

    issue(v);
    for (cyc = 0; cyc < 800 && post < 4; cyc++) begin
      @(negedge aclk);
      if (done) begin done_cnt++; resp_got = done_resp; end
      if (rd_valid) begin rgot.push_back(rd_data); rlg.push_back(rd_last); end
      if (done_cnt > 0) post++;
      if (!v.hold_cmd || done_cnt > 0) cmd_valid = 1'b0;
      awready = (v.mode == 1) ? coin() : 1'b1;
      arready = (v.mode == 1) ? coin() : 1'b1;
      if (!w_pend) begin
        if (v.wr && widx < nbeats) begin
          case (v.mode)
            0: wr_valid = 1'b1;
            1: wr_valid = coin();
            default: begin
              if (widx == 1 && gap < 2) begin wr_valid = 1'b0; gap++; end
              else wr_valid = 1'b1;
            end
          endcase
          wr_data = v.base + 32'(widx);
        end else wr_valid = 1'b0;
      end
      case (v.mode)
        0: wready = 1'b1;
        1: wready = coin();
        default: begin
          if (wgot.size() == 2 && stall < 3) begin wready = 1'b0; stall++; end
          else wready = 1'b1;
        end
      endcase
      bvalid = v.wr && (wgot.size() == nbeats) && !b_done;
      bresp  = v.resp;
      if (!r_pend) begin
        if (!v.wr && ar_done && rsent.size() < nsend && (v.mode != 1 || coin())) begin
          rvalid = 1'b1;
          rdata  = $urandom;
          rlast  = (rsent.size() == nsend - 1);
          rresp  = rlast ? v.resp : ((v.mode == 1) ? 2'($urandom_range(0, 1)) : 2'b00);
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
      #1;
      if (awvalid && awready) begin aw_cnt++; aw_f = {awaddr, awlen, awburst}; end
      if (arvalid && arready) begin ar_cnt++; ar_f = {araddr, arlen, arburst}; end
      if (wvalid !== (aw_done && wr_valid)) werr++;
      if (wvalid && wstrb !== 4'hF) werr++;
      if (prev_stall && (!wvalid || wdata !== prev_wdata)) werr++;
      prev_stall = wvalid && !wready;
      prev_wdata = wdata;
      if (wvalid && wready) begin
        wgot.push_back(wdata); wlg.push_back(wlast); widx++; w_pend = 1'b0;
      end else w_pend = wr_valid;
      if (bvalid && bready) b_done = 1'b1;
      if (rvalid && rready) begin
        rsent.push_back(rdata); rq.push_back(rresp); r_pend = 1'b0;
      end else r_pend = rvalid;
      if (awvalid && awready) aw_done = 1'b1;
      if (arvalid && arready) ar_done = 1'b1;
    end
    cmd_valid = 0; wr_valid = 0; wready = 0; bvalid = 0; rvalid = 0; rlast = 0;
    awready = 0; arready = 0;

    if (done_cnt == 0) $display("FAIL txn_timeout: got no done after %0d cycles, required 1", cyc);
    check("done_cnt", done_cnt, 1);
    exp = use_tbl ? v.exp_resp : model_resp(v, rq);
    check("done_resp", 64'(resp_got), 64'(exp));
    check("cmd_ready_after", 64'(cmd_ready), 1);
    if (v.wr) begin
      check("aw_cnt", aw_cnt, 1);
      check("aw_fields", 64'(aw_f), 64'({v.addr, v.len, v.burst}));
      if (wgot.size() != nbeats) err++;
      foreach (wgot[i]) begin
        if (wgot[i] !== v.base + 32'(i)) err++;
        if (wlg[i] !== (i == nbeats - 1)) err++;
      end
      check("wbeats", err, 0);
      check("wproto", werr, 0);
    end else begin
      check("ar_cnt", ar_cnt, 1);
      check("ar_fields", 64'(ar_f), 64'({v.addr, v.len, v.burst}));
      if (rgot.size() != rsent.size()) err++;
      foreach (rgot[i]) begin
        if (i < rsent.size() && rgot[i] !== rsent[i]) err++;
        if (rlg[i] !== (i == int'(v.len))) err++;
      end
      check("rbeats", err, 0);
    end
  endtask

  vec_t tbl[12];
  vec_t v;
  int   dcnt, cyc, k;
  bit   seen;
  logic [1:0] r;

  initial begin
    tbl[0]  = mk(1, 4'd1,  4'd3,  BURST_INCR,  RESP_OKAY,   0,  0, 32'd5,     0, RESP_OKAY);
    tbl[1]  = mk(1, 4'd1,  4'd3,  BURST_FIXED, RESP_OKAY,   0,  0, 32'h100,   0, RESP_OKAY);
    tbl[2]  = mk(1, 4'd1,  4'd6,  BURST_WRAP,  RESP_OKAY,   0,  0, 32'h200,   0, RESP_OKAY);
    tbl[3]  = mk(0, 4'd2,  4'd1,  BURST_INCR,  RESP_OKAY,   1,  0, 32'h0,     0, RESP_OKAY);
    tbl[4]  = mk(1, 4'd4,  4'd5,  BURST_INCR,  RESP_OKAY,   0,  2, 32'h300,   0, RESP_OKAY);
    tbl[5]  = mk(0, 4'd0,  4'd3,  BURST_INCR,  RESP_OKAY,   1,  0, 32'h0,     0, RESP_SLVERR);
    tbl[6]  = mk(0, 4'd5,  4'd1,  BURST_INCR,  RESP_OKAY,   3,  0, 32'h0,     0, RESP_SLVERR);
    tbl[7]  = mk(1, 4'd7,  4'd2,  BURST_INCR,  RESP_SLVERR, 0,  0, 32'h400,   0, RESP_SLVERR);
    tbl[8]  = mk(0, 4'd8,  4'd2,  BURST_FIXED, RESP_EXOKAY, 2,  0, 32'h0,     0, RESP_EXOKAY);
    tbl[9]  = mk(0, 4'd9,  4'd15, BURST_INCR,  RESP_OKAY,   15, 0, 32'h0,     0, RESP_OKAY);
    tbl[10] = mk(1, 4'd10, 4'd15, BURST_WRAP,  RESP_OKAY,   0,  1, 32'h500,   1, RESP_OKAY);
    tbl[11] = mk(1, 4'd11, 4'd0,  BURST_INCR,  RESP_EXOKAY, 0,  0, 32'h600,   1, RESP_EXOKAY);

    #3;
    check("reset_outputs", 64'(any_out()), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("reset_cmd_ready", 64'(cmd_ready), 1);

    for (int i = 0; i < 12; i++) run_txn(tbl[i], 1'b1);

    for (int i = 0; i < 24; i++) begin
      v = mk(coin(), 4'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 2)),
             2'($urandom_range(0, 3)), 0, 1, $urandom, coin(), RESP_OKAY);
      v.rlast_at = int'(v.len);
      if (!v.wr) begin
        k = int'($urandom_range(0, 4));
        if (k == 0 && v.len > 0) v.rlast_at = int'($urandom_range(0, int'(v.len) - 1));
        else if (k == 1 && v.len < 15) v.rlast_at = int'(v.len) + 1;
      end
      run_txn(v, 1'b0);
    end

    // Reset in the middle of a write data phase
    v = mk(1, 4'd3, 4'd7, BURST_INCR, RESP_OKAY, 0, 0, 32'h700, 0, RESP_OKAY);
    issue(v);
    @(negedge aclk);
    cmd_valid = 1'b0;
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0; wr_valid = 1'b1; wr_data = 32'h700; wready = 1'b1;
    @(negedge aclk);
    wr_data = 32'h701;
    @(negedge aclk);
    wr_data = 32'h702;
    #1;
    check("rst_mid_in_wdata", 64'(wvalid), 1);
    aresetn = 1'b0;
    #1;
    check("rst_mid_outputs", 64'(any_out()), 0);
    dcnt = 0;
    repeat (3) begin @(negedge aclk); if (done) dcnt++; end
    aresetn = 1'b1; wr_valid = 1'b0; wready = 1'b0;
    repeat (4) begin @(negedge aclk); if (done) dcnt++; end
    check("rst_mid_no_done", dcnt, 0);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 1);

    // Write whose address is never accepted
    v = mk(1, 4'd6, 4'd2, BURST_INCR, RESP_OKAY, 0, 0, 32'h0, 0, RESP_OKAY);
    issue(v);
    awready = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
    cyc = 0; seen = 0; r = 2'b00;
    while (!seen && cyc < 200) begin
      @(negedge aclk);
      cyc++;
      cmd_valid = 1'b0;
      if (done) begin seen = 1'b1; r = done_resp; end
    end
    check("tmo_done", 64'(seen), 1);
    check("tmo_resp", 64'(r), 64'(RESP_DECERR));
    check("tmo_window", 64'(cyc >= 60 && cyc <= 70), 1);
    #1;
    check("tmo_awvalid_drop", 64'(awvalid), 0);
`else
    dcnt = 0;
    repeat (100) begin
      @(negedge aclk);
      cmd_valid = 1'b0;
      if (done) dcnt++;
    end
    check("no_tmo_done", dcnt, 0);
    check("no_tmo_awvalid", 64'(awvalid), 1);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
